// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// Independent AW/W capture, byte-strobed commit, registered B and R responses.
module axi4_lite_slave_regfile #(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [31:0]              s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned WORD_W = 30;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                aw_held_q, aw_held_d;
  logic                aw_legal_q, aw_legal_d;
  logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
  logic                w_held_q, w_held_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic aw_hs, w_hs, ar_hs, ar_legal;
  logic [IDX_W-1:0] ar_idx;

  // Word-offset bits 1:0 are deliberately ignored by the decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = !rst && !aw_held_q && !bvalid_q;
  assign s_axi_wready  = !rst && !w_held_q && !bvalid_q;
  assign s_axi_arready = !rst && !rvalid_q;

  assign aw_hs    = s_axi_awvalid && s_axi_awready;
  assign w_hs     = s_axi_wvalid && s_axi_wready;
  assign ar_hs    = s_axi_arvalid && s_axi_arready;
  assign ar_legal = s_axi_araddr[31:2] < WORD_W'(NUM_REGS);
  assign ar_idx   = s_axi_araddr[IDX_W+1:2];

  // Next-state: channel capture, write commit, response handshakes.
  always_comb begin
    regs_d     = regs_q;
    aw_held_d  = aw_held_q;
    aw_legal_d = aw_legal_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    wr_pulse_d = '0;

    if (aw_hs) begin
      aw_held_d  = 1'b1;
      aw_legal_d = s_axi_awaddr[31:2] < WORD_W'(NUM_REGS);
      aw_idx_d   = s_axi_awaddr[IDX_W+1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    // Held flags can only both be set while no response is outstanding.
    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (aw_legal_q) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (wstrb_q[b]) regs_d[aw_idx_q][8*b +: 8] = wdata_q[8*b +: 8];
        end
        wr_pulse_d[aw_idx_q] = 1'b1;
        bresp_d = RESP_OKAY;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end

    // Reads sample the pre-edge register value, so a same-edge commit is not seen.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_legal ? regs_q[ar_idx] : '0;
      rresp_d  = ar_legal ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
      aw_held_q  <= 1'b0;
      aw_legal_q <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
      aw_held_q  <= aw_held_d;
      aw_legal_q <= aw_legal_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign reg_out[32*k +: 32] = regs_q[k];
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;
  assign wr_pulse     = wr_pulse_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Self-checking bench for axi4_lite_slave_regfile: directed scenarios plus
// randomized traffic against an array-based register model.
module tb_axi4_lite_slave_regfile;

  localparam int unsigned NR = 16;
  localparam logic [31:0] RV = 32'h0BAD_F00D;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;
  logic [NR*32-1:0] reg_out;
  logic [NR-1:0] wr_pulse;

  axi4_lite_slave_regfile #(.NUM_REGS(NR), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  logic [31:0] model [NR];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int k = 0; k < int'(NR); k++) f[32*k +: 32] = model[k];
    return f;
  endfunction

  // Drives one write with independent AW/W delays; reports response, pulse,
  // edges from last handshake to bvalid, and cycles a finished channel showed ready.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output logic [NR-1:0] pulse,
                           output int lat, output int leak, output bit to);
    bit aw_done, w_done, aw_hs, w_hs;
    int c;
    aw_done = 0; w_done = 0; c = 0; lat = 0; leak = 0; to = 0; resp = 2'b11; pulse = '0;
    while (!(aw_done && w_done) && !to) begin
      awvalid = !aw_done && (c >= aw_dly); awaddr = addr;
      wvalid  = !w_done && (c >= w_dly);   wdata = data; wstrb = strb;
      if ((aw_done && awready) || (w_done && wready)) leak++;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      c++;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      if (c > 50) to = 1;
    end
    awvalid = 0; wvalid = 0;
    while (!bvalid && !to) begin
      if (awready || wready) leak++;
      tick();
      lat++;
      if (lat > 20) to = 1;
    end
    resp = bresp; pulse = wr_pulse;
    bready = 1; tick(); bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rready_dly,
                          output logic [31:0] data, output logic [1:0] resp,
                          output logic rv, output bit to);
    int c;
    c = 0; to = 0;
    arvalid = 1; araddr = addr;
    while (!arready && !to) begin
      tick(); c++;
      if (c > 20) to = 1;
    end
    tick();
    arvalid = 0;
    data = rdata; resp = rresp; rv = rvalid;
    repeat (rready_dly) tick();
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_reset();
    rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    for (int k = 0; k < int'(NR); k++) model[k] = RV;
    repeat (3) tick();
    n_cmp++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_fail++; $display("FAIL rst_readies: got %b expected 000", {awready, wready, arready});
    end
    n_cmp++;
    if ({bvalid, rvalid, bresp, rresp, rdata, wr_pulse} !== '0) begin
      n_fail++; $display("FAIL rst_outputs: got bv=%b rv=%b br=%b rr=%b rd=%h wp=%h expected all zero",
                         bvalid, rvalid, bresp, rresp, rdata, wr_pulse);
    end
    n_cmp++;
    if (reg_out !== model_flat()) begin
      n_fail++; $display("FAIL rst_regs: got %h expected %h", reg_out, model_flat());
    end
    rst = 0; #1;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL rst_release_readies: got %b expected 111", {awready, wready, arready});
    end
    tick();
  endtask

  task automatic test_write_basic();
    logic [1:0] r; logic [NR-1:0] p; int lat, leak; bit to;
    axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, r, p, lat, leak, to);
    model[2] = 32'hDEAD_BEEF;
    n_cmp++;
    if (to || lat != 1) begin
      n_fail++; $display("FAIL basic_latency: got lat=%0d to=%0d expected lat=1 to=0", lat, to);
    end
    n_cmp++;
    if ({r, p} !== {2'b00, 16'h0004}) begin
      n_fail++; $display("FAIL basic_resp_pulse: got bresp=%b pulse=%h expected 00 0004", r, p);
    end
    n_cmp++;
    if (reg_out[95:64] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL basic_reg2: got %h expected deadbeef", reg_out[95:64]);
    end
    n_cmp++;
    if (wr_pulse !== '0) begin
      n_fail++; $display("FAIL basic_pulse_width: got %h expected 0000", wr_pulse);
    end
  endtask

  task automatic test_strobe_order();
    logic [1:0] r; logic [NR-1:0] p; int lat, leak; bit to;
    axi_write(32'h0C, 32'hAAAA_AAAA, 4'hF, 0, 0, r, p, lat, leak, to);
    model[3] = 32'hAAAA_AAAA;
    axi_write(32'h0C, 32'h1122_3344, 4'b0101, 3, 0, r, p, lat, leak, to);
    model[3] = merge(model[3], 32'h1122_3344, 4'b0101);
    n_cmp++;
    if (to || leak != 0 || lat != 1) begin
      n_fail++; $display("FAIL order_ready_low: got leak=%0d lat=%0d to=%0d expected 0 1 0", leak, lat, to);
    end
    n_cmp++;
    if (reg_out[127:96] !== 32'hAA22_AA44 || model[3] !== 32'hAA22_AA44) begin
      n_fail++; $display("FAIL order_strobe: got %h expected aa22aa44", reg_out[127:96]);
    end
    axi_write(32'h0D, 32'hFFFF_FFFF, 4'b0000, 1, 2, r, p, lat, leak, to);
    n_cmp++;
    if ({r, p} !== {2'b00, 16'h0008} || reg_out !== model_flat()) begin
      n_fail++; $display("FAIL zero_strobe: got bresp=%b pulse=%h reg3=%h expected 00 0008 %h",
                         r, p, reg_out[127:96], model[3]);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [NR-1:0] p; int lat, leak; bit to;
    logic [31:0] d; logic rv;
    axi_write(32'h40, 32'h0F0F_0F0F, 4'hF, 0, 1, r, p, lat, leak, to);
    n_cmp++;
    if (to || {r, p} !== {2'b10, 16'h0000} || reg_out !== model_flat()) begin
      n_fail++; $display("FAIL oor_write: got bresp=%b pulse=%h to=%0d expected 10 0000 no change", r, p, to);
    end
    axi_write(32'hFFFF_FFF0, 32'h1, 4'hF, 2, 0, r, p, lat, leak, to);
    n_cmp++;
    if (to || {r, p} !== {2'b10, 16'h0000} || reg_out !== model_flat()) begin
      n_fail++; $display("FAIL oor_write_high: got bresp=%b pulse=%h expected 10 0000", r, p);
    end
    axi_read(32'h44, 0, d, r, rv, to);
    n_cmp++;
    if (to || {rv, r, d} !== {1'b1, 2'b10, 32'h0}) begin
      n_fail++; $display("FAIL oor_read: got rv=%b rresp=%b rdata=%h expected 1 10 00000000", rv, r, d);
    end
  endtask

  task automatic test_bresp_backpressure();
    awaddr = 32'h14; wdata = 32'h5555_0001; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    model[5] = 32'h5555_0001;
    awaddr = 32'h18; wdata = 32'h0000_7777; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bvalid, bresp, awready, wready} !== 5'b1_00_0_0 || reg_out !== model_flat()) begin
        n_fail++; $display("FAIL b_hold_%0d: got bv=%b br=%b awr=%b wr=%b reg6=%h expected 1 00 0 0 %h",
                           i, bvalid, bresp, awready, wready, reg_out[223:192], model[6]);
      end
      tick();
    end
    bready = 1; tick(); bready = 0;
    n_cmp++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_fail++; $display("FAIL b_release: got bv=%b awr=%b wr=%b expected 0 1 1", bvalid, awready, wready);
    end
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    model[6] = 32'h0000_7777;
    n_cmp++;
    if ({bvalid, bresp, wr_pulse} !== {1'b1, 2'b00, 16'h0040} || reg_out !== model_flat()) begin
      n_fail++; $display("FAIL b_second_write: got bv=%b br=%b wp=%h reg6=%h expected 1 00 0040 00007777",
                         bvalid, bresp, wr_pulse, reg_out[223:192]);
    end
    bready = 1; tick(); bready = 0;
  endtask

  task automatic test_collision();
    logic [1:0] r; logic [NR-1:0] p; int lat, leak; bit to;
    logic [31:0] d; logic rv;
    axi_write(32'h04, 32'h5, 4'hF, 0, 0, r, p, lat, leak, to);
    model[1] = 32'h5;
    awaddr = 32'h04; wdata = 32'h9; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; araddr = 32'h04; arvalid = 1;
    tick();
    arvalid = 0;
    n_cmp++;
    if ({rvalid, rresp, rdata, bvalid} !== {1'b1, 2'b00, 32'h5, 1'b1} || reg_out[63:32] !== 32'h9) begin
      n_fail++; $display("FAIL collision: got rv=%b rr=%b rd=%h bv=%b reg1=%h expected 1 00 5 1 9",
                         rvalid, rresp, rdata, bvalid, reg_out[63:32]);
    end
    model[1] = 32'h9;
    bready = 1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({rvalid, arready, rdata} !== {1'b1, 1'b0, 32'h5}) begin
        n_fail++; $display("FAIL r_hold_%0d: got rv=%b arr=%b rd=%h expected 1 0 5", i, rvalid, arready, rdata);
      end
      tick();
      bready = 0;
    end
    rready = 1; tick(); rready = 0;
    n_cmp++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++; $display("FAIL r_release: got rv=%b arr=%b expected 0 1", rvalid, arready);
    end
    axi_read(32'h04, 1, d, r, rv, to);
    n_cmp++;
    if (to || {rv, r, d} !== {1'b1, 2'b00, 32'h9}) begin
      n_fail++; $display("FAIL collision_reread: got rv=%b rr=%b rd=%h expected 1 00 9", rv, r, d);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      logic [31:0] a, d, got;
      logic [3:0] s;
      logic [1:0] r;
      logic [NR-1:0] p, exp_p;
      logic rv;
      int lat, leak, ix;
      bit to, lg;
      a = (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h8000_0000;
      lg = (a >> 2) < NR;
      ix = int'(a[5:2]);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), r, p, lat, leak, to);
        exp_p = lg ? NR'(1) << ix : '0;
        if (lg) model[ix] = merge(model[ix], d, s);
        n_cmp++;
        if (to || lat != 1 || leak != 0) begin
          n_fail++; $display("FAIL rnd_wr_timing_%0d: got lat=%0d leak=%0d to=%0d expected 1 0 0", it, lat, leak, to);
        end
        n_cmp++;
        if ({r, p} !== {(lg ? 2'b00 : 2'b10), exp_p} || reg_out !== model_flat()) begin
          n_fail++; $display("FAIL rnd_wr_%0d: addr=%h got bresp=%b pulse=%h expected %b %h (or regs differ)",
                             it, a, r, p, lg ? 2'b00 : 2'b10, exp_p);
        end
      end else begin
        axi_read(a, $urandom_range(0, 2), got, r, rv, to);
        n_cmp++;
        if (to || {rv, r, got} !== {1'b1, (lg ? 2'b00 : 2'b10), (lg ? model[ix] : 32'h0)}) begin
          n_fail++; $display("FAIL rnd_rd_%0d: addr=%h got rv=%b rr=%b rd=%h expected 1 %b %h",
                             it, a, rv, r, got, lg ? 2'b00 : 2'b10, lg ? model[ix] : 32'h0);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [NR-1:0] p; int lat, leak; bit to;
    axi_write(32'h08, 32'h1234, 4'hF, 0, 0, r, p, lat, leak, to);
    araddr = 32'h08; arvalid = 1; awaddr = 32'h10; awvalid = 1;
    tick();
    arvalid = 0; awvalid = 0;
    n_cmp++;
    if ({rvalid, rdata} !== {1'b1, 32'h1234}) begin
      n_fail++; $display("FAIL mid_pending_read: got rv=%b rd=%h expected 1 00001234", rvalid, rdata);
    end
    rst = 1; #1;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst_readies: got %b expected 000", {awready, wready, arready});
    end
    tick();
    for (int k = 0; k < int'(NR); k++) model[k] = RV;
    n_cmp++;
    if ({rvalid, bvalid, rdata, rresp, wr_pulse} !== '0 || reg_out !== model_flat()) begin
      n_fail++; $display("FAIL mid_rst_state: got rv=%b bv=%b rd=%h rr=%b wp=%h reg2=%h expected zeros, regs %h",
                         rvalid, bvalid, rdata, rresp, wr_pulse, reg_out[95:64], RV);
    end
    rst = 0; #1;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL mid_release_readies: got %b expected 111", {awready, wready, arready});
    end
    tick();
    wdata = 32'hCAFE; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    repeat (3) tick();
    n_cmp++;
    if (bvalid !== 1'b0 || reg_out !== model_flat()) begin
      n_fail++; $display("FAIL mid_aw_discarded: got bv=%b reg4=%h expected 0 %h", bvalid, reg_out[159:128], RV);
    end
    awaddr = 32'h10; awvalid = 1;
    tick();
    awvalid = 0;
    tick();
    model[4] = 32'hCAFE;
    n_cmp++;
    if ({bvalid, bresp} !== 3'b100 || reg_out !== model_flat()) begin
      n_fail++; $display("FAIL mid_recover_write: got bv=%b br=%b reg4=%h expected 1 00 0000cafe",
                         bvalid, bresp, reg_out[159:128]);
    end
    bready = 1; tick(); bready = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_strobe_order();
    test_out_of_range();
    test_bresp_backpressure();
    test_collision();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
